// File: rtl/iic_uart_pkg.sv
// Shared constants and types for the IIC register bridge with UART write monitor.
// Build option: IIC_UART_CHKSUM_EN appends an XOR checksum byte to every packet.
package iic_uart_pkg;

  localparam logic [7:0] PKT_HDR = 8'hA5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BITS  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

`ifdef IIC_UART_CHKSUM_EN
  localparam logic [2:0] PKT_LEN = 3'd4;
`else
  localparam logic [2:0] PKT_LEN = 3'd3;
`endif

  localparam int EVT_W = 16;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } evt_t;

  // Byte idx of the packet for one write event: header, addr, data [, checksum].
  function automatic logic [7:0] pkt_byte(input evt_t evt, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd1:    b = evt.addr;
      3'd2:    b = evt.data;
`ifdef IIC_UART_CHKSUM_EN
      3'd3:    b = PKT_HDR ^ evt.addr ^ evt.data;
`endif
      default: b = PKT_HDR;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser with valid/ready handshake; ready is also raised in the last
// stop-bit cycle so a waiting byte follows with no idle gap.
module uart_tx_byte
  import iic_uart_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       txd
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  logic [1:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic          txd_reg;
  logic          tick;

  assign tick  = (cnt_reg == CNT_LAST);
  assign ready = (state_reg == S_IDLE) || (state_reg == S_STOP && tick);
  assign txd   = txd_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      txd_reg   <= 1'b1;
    end else if (ready && valid) begin
      state_reg <= S_START;
      cnt_reg   <= '0;
      shift_reg <= data;
      txd_reg   <= 1'b0;
    end else begin
      cnt_reg <= (state_reg == S_IDLE || tick) ? '0 : cnt_reg + CW'(1);
      if (tick) begin
        case (state_reg)
          S_START: begin
            state_reg <= S_BITS;
            bit_reg   <= '0;
            txd_reg   <= shift_reg[0];
          end
          S_BITS: begin
            if (bit_reg == 3'd7) begin
              state_reg <= S_STOP;
              txd_reg   <= 1'b1;
            end else begin
              bit_reg   <= bit_reg + 3'd1;
              shift_reg <= shift_reg >> 1;
              txd_reg   <= shift_reg[1];
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/iic_reg_uart_bridge.sv
// 256-byte IIC register file that also queues every write and streams it as a UART packet.
// Build option: IIC_UART_CHKSUM_EN (see iic_uart_pkg) adds a checksum byte per packet.
module iic_reg_uart_bridge
  import iic_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic [7:0] rd_data,
  output logic       uart_txd,
  output logic       fifo_full,
  output logic [7:0] ovf_cnt
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic       wr_en_d_reg;
  logic       accept;
  logic [7:0] mem [256];
  logic [7:0] rd_data_reg;

  evt_t          fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wptr_reg, rptr_reg, wptr_next, rptr_next;
  logic          full_reg, full_next, empty, push, pop;
  logic [7:0]    ovf_reg;
  evt_t          head;

  evt_t       pkt_reg;
  logic [2:0] byte_idx_reg;
  logic       pkt_valid_reg;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_byte;

  assign accept = wr_en & ~wr_en_d_reg;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_reg <= '0;
      wr_en_d_reg <= 1'b0;
    end else begin
      rd_data_reg <= mem[wr_addr];
      wr_en_d_reg <= wr_en;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign empty = (wptr_reg == rptr_reg);
  assign push  = accept && (!full_reg || pop);
  assign head  = fifo_mem[rptr_reg[AW-1:0]];

  always_comb begin
    wptr_next = wptr_reg + (AW+1)'(push);
    rptr_next = rptr_reg + (AW+1)'(pop);
    full_next = ((wptr_next - rptr_next) == (AW+1)'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_reg[AW-1:0]] <= '{addr: wr_addr, data: wr_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      full_reg <= 1'b0;
      ovf_reg  <= '0;
    end else begin
      wptr_reg <= wptr_next;
      rptr_reg <= rptr_next;
      full_reg <= full_next;
      if (accept && !push && ovf_reg != 8'hFF) ovf_reg <= ovf_reg + 8'd1;
    end
  end

  // While the last byte is on the wire the next header is offered straight from the
  // FIFO head; it is taken (and popped) exactly when that byte's stop bit ends.
  always_comb begin
    tx_valid = 1'b0;
    tx_byte  = PKT_HDR;
    pop      = 1'b0;
    if (!pkt_valid_reg) begin
      pop = !empty;
    end else if (byte_idx_reg != PKT_LEN) begin
      tx_valid = 1'b1;
      tx_byte  = pkt_byte(pkt_reg, byte_idx_reg);
    end else begin
      tx_valid = !empty;
      pop      = !empty && tx_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_valid_reg <= 1'b0;
      byte_idx_reg  <= '0;
      pkt_reg       <= '0;
    end else if (!pkt_valid_reg) begin
      if (pop) begin
        pkt_valid_reg <= 1'b1;
        byte_idx_reg  <= '0;
        pkt_reg       <= head;
      end
    end else if (byte_idx_reg != PKT_LEN) begin
      if (tx_ready) byte_idx_reg <= byte_idx_reg + 3'd1;
    end else if (tx_ready) begin
      if (pop) begin
        pkt_reg      <= head;
        byte_idx_reg <= 3'd1;
      end else begin
        pkt_valid_reg <= 1'b0;
      end
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .data (tx_byte),
    .valid(tx_valid),
    .ready(tx_ready),
    .txd  (uart_txd)
  );

  assign rd_data   = rd_data_reg;
  assign fifo_full = full_reg;
  assign ovf_cnt   = ovf_reg;

endmodule
